// File: rtl/ctrl_sequencer_if.sv
// Control bus between the hardwired sequencer and the mini CPU datapath.
// master = sequencer (drives strobes), slave = datapath/memory side.
interface ctrl_sequencer_if;
   logic [4:0] opcode;
   logic       mem_ready;
   logic       PCout, PCin, IncPC;
   logic       MARin, MDRin, MDRout, IRin;
   logic       Yin, Zin, Zlowout, Cout;
   logic       Read, Write;
   logic       Gra, Grb, Grc, Rin, Rout, BAout;
   logic [1:0] alu_op;
   logic       run, fault;

   modport master (
      input  opcode, mem_ready,
      output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
             Yin, Zin, Zlowout, Cout, Read, Write,
             Gra, Grb, Grc, Rin, Rout, BAout, alu_op, run, fault
   );

   modport slave (
      output opcode, mem_ready,
      input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
             Yin, Zin, Zlowout, Cout, Read, Write,
             Gra, Grb, Grc, Rin, Rout, BAout, alu_op, run, fault
   );
endinterface

// File: rtl/ctrl_sequencer.sv
// Hardwired Moore control unit: fetch/decode/execute T-states with
// memory-ready handshake, halt and sticky memory-timeout fault.
module ctrl_sequencer #(
   parameter int unsigned MEM_WAIT_MAX = 15,
   parameter int unsigned WCNT_W       = 4
) (
   input logic              clock,
   input logic              clear,
   ctrl_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
   } state_t;

   typedef enum logic [2:0] {
      C_NOP, C_HALT, C_ALU, C_IMM, C_LDI, C_LD, C_ST
   } cls_t;

   typedef struct packed {
      logic       PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
      logic       Yin, Zin, Zlowout, Cout, Read, Write;
      logic       Gra, Grb, Grc, Rin, Rout, BAout;
      logic [1:0] alu_op;
      logic       run, fault;
   } ctrl_t;

   state_t            state, state_nxt;
   cls_t              cls, cls_nxt, dec_cls;
   logic [1:0]        aop, aop_nxt, dec_aop;
   logic [WCNT_W-1:0] wcnt, wcnt_nxt;
   logic              in_wait;
   ctrl_t             ctrl_q;

   // Strobes for a state; class/alu code are registers latched at end of T2.
   function automatic ctrl_t ctrl_of(state_t s, cls_t c, logic [1:0] a);
      ctrl_t k;
      k = '0;
      case (s)
         S_T0: begin k.PCout = 1'b1; k.MARin = 1'b1; k.IncPC = 1'b1; k.Zin = 1'b1; end
         S_T1: begin k.Zlowout = 1'b1; k.PCin = 1'b1; k.Read = 1'b1; k.MDRin = 1'b1; end
         S_T2: begin k.MDRout = 1'b1; k.IRin = 1'b1; end
         S_T3: begin
            if (c == C_ALU || c == C_IMM) begin
               k.Grb = 1'b1; k.Rout = 1'b1; k.Yin = 1'b1;
            end else if (c == C_LDI || c == C_LD || c == C_ST) begin
               k.Grb = 1'b1; k.BAout = 1'b1; k.Yin = 1'b1;
            end
         end
         S_T4: begin
            k.Zin    = 1'b1;
            k.alu_op = a;
            if (c == C_ALU) begin k.Grc = 1'b1; k.Rout = 1'b1; end
            else            k.Cout = 1'b1;
         end
         S_T5: begin
            k.Zlowout = 1'b1;
            if (c == C_LD || c == C_ST) k.MARin = 1'b1;
            else begin k.Gra = 1'b1; k.Rin = 1'b1; end
         end
         S_T6: begin
            k.MDRin = 1'b1;
            if (c == C_LD) k.Read = 1'b1;
            else begin k.Gra = 1'b1; k.Rout = 1'b1; end
         end
         S_T7: begin
            if (c == C_LD) begin k.MDRout = 1'b1; k.Gra = 1'b1; k.Rin = 1'b1; end
            else           k.Write = 1'b1;
         end
         default: k = '0;
      endcase
      k.run   = !(s == S_RST || s == S_HALT || s == S_FAULT);
      k.fault = (s == S_FAULT);
      return k;
   endfunction

   always_comb begin
      dec_cls = C_NOP;
      dec_aop = 2'd0;
      case (bus.opcode)
         5'b00000: dec_cls = C_LD;
         5'b00001: dec_cls = C_LDI;
         5'b00010: dec_cls = C_ST;
         5'b00011: begin dec_cls = C_ALU; dec_aop = 2'd0; end
         5'b00100: begin dec_cls = C_ALU; dec_aop = 2'd1; end
         5'b00101: begin dec_cls = C_ALU; dec_aop = 2'd2; end
         5'b00110: begin dec_cls = C_ALU; dec_aop = 2'd3; end
         5'b01100: begin dec_cls = C_IMM; dec_aop = 2'd0; end
         5'b01101: begin dec_cls = C_IMM; dec_aop = 2'd2; end
         5'b01110: begin dec_cls = C_IMM; dec_aop = 2'd3; end
         5'b11011: dec_cls = C_HALT;
         default:  dec_cls = C_NOP;
      endcase
   end

   assign in_wait = (state == S_T1) ||
                    (state == S_T6 && cls == C_LD) ||
                    (state == S_T7 && cls == C_ST);

   always_comb begin
      state_nxt = state;
      cls_nxt   = cls;
      aop_nxt   = aop;
      wcnt_nxt  = '0;
      case (state)
         S_RST: state_nxt = S_T0;
         S_T0:  state_nxt = S_T1;
         S_T1:  state_nxt = S_T2;
         S_T2: begin
            state_nxt = S_T3;
            cls_nxt   = dec_cls;
            aop_nxt   = dec_aop;
         end
         S_T3: begin
            if (cls == C_NOP)       state_nxt = S_T0;
            else if (cls == C_HALT) state_nxt = S_HALT;
            else                    state_nxt = S_T4;
         end
         S_T4:  state_nxt = S_T5;
         S_T5:  state_nxt = (cls == C_LD || cls == C_ST) ? S_T6 : S_T0;
         S_T6:  state_nxt = S_T7;
         S_T7:  state_nxt = S_T0;
         default: state_nxt = state;
      endcase
      // Ready on the last allowed cycle still counts as success.
      if (in_wait && !bus.mem_ready) begin
         if (wcnt == WCNT_W'(MEM_WAIT_MAX)) begin
            state_nxt = S_FAULT;
         end else begin
            state_nxt = state;
            wcnt_nxt  = wcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!clear) begin
         state  <= S_RST;
         cls    <= C_NOP;
         aop    <= 2'd0;
         wcnt   <= '0;
         ctrl_q <= '0;
      end else begin
         state  <= state_nxt;
         cls    <= cls_nxt;
         aop    <= aop_nxt;
         wcnt   <= wcnt_nxt;
         ctrl_q <= ctrl_of(state_nxt, cls_nxt, aop_nxt);
      end
   end

   assign bus.PCout   = ctrl_q.PCout;
   assign bus.PCin    = ctrl_q.PCin;
   assign bus.IncPC   = ctrl_q.IncPC;
   assign bus.MARin   = ctrl_q.MARin;
   assign bus.MDRin   = ctrl_q.MDRin;
   assign bus.MDRout  = ctrl_q.MDRout;
   assign bus.IRin    = ctrl_q.IRin;
   assign bus.Yin     = ctrl_q.Yin;
   assign bus.Zin     = ctrl_q.Zin;
   assign bus.Zlowout = ctrl_q.Zlowout;
   assign bus.Cout    = ctrl_q.Cout;
   assign bus.Read    = ctrl_q.Read;
   assign bus.Write   = ctrl_q.Write;
   assign bus.Gra     = ctrl_q.Gra;
   assign bus.Grb     = ctrl_q.Grb;
   assign bus.Grc     = ctrl_q.Grc;
   assign bus.Rin     = ctrl_q.Rin;
   assign bus.Rout    = ctrl_q.Rout;
   assign bus.BAout   = ctrl_q.BAout;
   assign bus.alu_op  = ctrl_q.alu_op;
   assign bus.run     = ctrl_q.run;
   assign bus.fault   = ctrl_q.fault;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: per-instruction expected strobe schedules
// built from opcode tables, random opcodes, waits and idle mem_ready.
module tb_ctrl_sequencer;
   localparam int unsigned MAXW = 15;

   typedef logic [22:0] w_t;
   localparam w_t M_PCOUT  = w_t'(1) << 22;
   localparam w_t M_PCIN   = w_t'(1) << 21;
   localparam w_t M_INCPC  = w_t'(1) << 20;
   localparam w_t M_MARIN  = w_t'(1) << 19;
   localparam w_t M_MDRIN  = w_t'(1) << 18;
   localparam w_t M_MDROUT = w_t'(1) << 17;
   localparam w_t M_IRIN   = w_t'(1) << 16;
   localparam w_t M_YIN    = w_t'(1) << 15;
   localparam w_t M_ZIN    = w_t'(1) << 14;
   localparam w_t M_ZLOW   = w_t'(1) << 13;
   localparam w_t M_COUT   = w_t'(1) << 12;
   localparam w_t M_READ   = w_t'(1) << 11;
   localparam w_t M_WRITE  = w_t'(1) << 10;
   localparam w_t M_GRA    = w_t'(1) << 9;
   localparam w_t M_GRB    = w_t'(1) << 8;
   localparam w_t M_GRC    = w_t'(1) << 7;
   localparam w_t M_RIN    = w_t'(1) << 6;
   localparam w_t M_ROUT   = w_t'(1) << 5;
   localparam w_t M_BAOUT  = w_t'(1) << 4;
   localparam w_t M_RUN    = w_t'(1) << 1;
   localparam w_t M_FLT    = w_t'(1);

   localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
   localparam logic [4:0] OP_ADD = 5'b00011, OP_HALT = 5'b11011, OP_NOP = 5'b11010;

   logic clock = 1'b0;
   logic clear;
   always #5 clock = ~clock;

   ctrl_sequencer_if bus();

   ctrl_sequencer #(.MEM_WAIT_MAX(MAXW), .WCNT_W(4)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   w_t obs;
   assign obs = {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.MDRin, bus.MDRout,
                 bus.IRin, bus.Yin, bus.Zin, bus.Zlowout, bus.Cout, bus.Read,
                 bus.Write, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.BAout,
                 bus.alu_op, bus.run, bus.fault};

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   int unsigned cyc   = 0;

   w_t         exp_q[$];
   logic       mr_q[$];
   logic [4:0] op_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] rop();
      return 5'($urandom_range(0, 31));
   endfunction

   function automatic logic rmr(input bit tied);
      return tied ? 1'b1 : 1'($urandom_range(0, 1));
   endfunction

   function automatic int unsigned pick_wait();
      int unsigned r;
      r = $urandom_range(0, 15);
      if (r == 0) return MAXW;
      if (r < 8)  return 0;
      return $urandom_range(1, 5);
   endfunction

   task automatic push(input w_t w, input logic mr, input logic [4:0] op);
      exp_q.push_back(w);
      mr_q.push_back(mr);
      op_q.push_back(op);
   endtask

   // nw cycles of mem_ready=0 then one ready cycle; beyond MAXW the bus times out.
   task automatic push_wait(input w_t w, input int unsigned nw, input logic [4:0] op,
                            output bit flt);
      flt = 1'b0;
      if (nw <= MAXW) begin
         repeat (nw) push(w, 1'b0, op);
         push(w, 1'b1, op);
      end else begin
         repeat (MAXW + 1) push(w, 1'b0, op);
         flt = 1'b1;
      end
   endtask

   task automatic build(input logic [4:0] op, input int unsigned wf, input int unsigned wm,
                        input bit tied);
      bit flt;
      w_t ao;
      push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN, rmr(tied), rop());
      push_wait(M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN, wf, rop(), flt);
      if (!flt) begin
         push(M_MDROUT | M_IRIN | M_RUN, rmr(tied), op);
         case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
               ao = w_t'(op - 5'd3) << 2;
               push(M_GRB | M_ROUT | M_YIN | M_RUN, rmr(tied), op);
               push(M_GRC | M_ROUT | M_ZIN | ao | M_RUN, rmr(tied), op);
               push(M_ZLOW | M_GRA | M_RIN | M_RUN, rmr(tied), op);
            end
            5'b01100, 5'b01101, 5'b01110: begin
               ao = (op == 5'b01100) ? w_t'(0) : (op == 5'b01101) ? w_t'(2 << 2) : w_t'(3 << 2);
               push(M_GRB | M_ROUT | M_YIN | M_RUN, rmr(tied), op);
               push(M_COUT | M_ZIN | ao | M_RUN, rmr(tied), op);
               push(M_ZLOW | M_GRA | M_RIN | M_RUN, rmr(tied), op);
            end
            OP_LDI, OP_LD, OP_ST: begin
               push(M_GRB | M_BAOUT | M_YIN | M_RUN, rmr(tied), op);
               push(M_COUT | M_ZIN | M_RUN, rmr(tied), op);
               if (op == OP_LDI) begin
                  push(M_ZLOW | M_GRA | M_RIN | M_RUN, rmr(tied), op);
               end else begin
                  push(M_ZLOW | M_MARIN | M_RUN, rmr(tied), op);
                  if (op == OP_LD) begin
                     push_wait(M_READ | M_MDRIN | M_RUN, wm, op, flt);
                     if (!flt) push(M_MDROUT | M_GRA | M_RIN | M_RUN, rmr(tied), op);
                  end else begin
                     push(M_GRA | M_ROUT | M_MDRIN | M_RUN, rmr(tied), op);
                     push_wait(M_WRITE | M_RUN, wm, op, flt);
                  end
               end
            end
            default: push(M_RUN, rmr(tied), op);
         endcase
      end
      if (flt) repeat (8) push(M_FLT, rmr(tied), rop());
   endtask

   task automatic trim(input int unsigned n);
      while (exp_q.size() > n) begin
         void'(exp_q.pop_back());
         void'(mr_q.pop_back());
         void'(op_q.pop_back());
      end
   endtask

   task automatic play(input string name);
      while (exp_q.size() > 0) begin
         @(negedge clock);
         cyc++;
         chk($sformatf("%s@%0d", name, cyc), 32'(obs), 32'(exp_q.pop_front()));
         bus.mem_ready = mr_q.pop_front();
         bus.opcode    = op_q.pop_front();
      end
   endtask

   task automatic do_reset();
      clear = 1'b0;
      repeat (3) begin
         @(negedge clock);
         cyc++;
         chk($sformatf("reset@%0d", cyc), 32'(obs), 32'd0);
         bus.mem_ready = rmr(1'b0);
         bus.opcode    = rop();
      end
      clear = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [4:0] op;
      clear         = 1'b0;
      bus.mem_ready = 1'b0;
      bus.opcode    = 5'd0;
      do_reset();

      build(OP_ADD, 0, 0, 1'b1);
      play("add");

      build(OP_ADD, 0, 0, 1'b1);
      trim(5);
      play("add_to_t4");
      do_reset();

      build(OP_LD, 0, 3, 1'b0);
      play("ld_wait3");

      repeat (3) begin
         build(5'b10101, 0, 0, 1'b0);
         play("undef");
      end

      build(OP_LD, MAXW, MAXW, 1'b0);
      play("ld_wait_max");

      build(OP_LD, 0, 10, 1'b0);
      trim(9);
      play("ld_abort");
      do_reset();

      for (int i = 0; i < 40; i++) begin
         op = rop();
         if (op == OP_HALT) op = OP_NOP;
         build(op, pick_wait(), pick_wait(), 1'b0);
         play("rand");
      end

      build(OP_ST, 0, MAXW + 1, 1'b0);
      play("st_timeout");
      do_reset();

      build(OP_HALT, 0, 0, 1'b0);
      repeat (20) push(w_t'(0), rmr(1'b0), OP_ADD);
      play("halt");
      do_reset();

      build(OP_LDI, 2, 0, 1'b0);
      play("ldi_after");
      build(OP_ADD, 0, 0, 1'b1);
      play("add_after");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Hardwired Moore control unit for the mini CPU bus datapath.
- Steps each instruction through fetch, decode and execute T-states.
- Drives the register-select strobes (Gra/Grb/Grc/Rin/Rout/BAout) into sel_encode, plus PC, MAR, MDR, IR, Y, Z, C-sign-extend and ALU controls.
- Handshakes with memory through mem_ready. Stops on halt or on a memory timeout.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles a Read/Write state may wait for mem_ready before a fault.
- WCNT_W, 4: width of the wait counter; must satisfy 2^WCNT_W > MEM_WAIT_MAX.

Ports:
- clock, input, 1: system clock, rising edge.
- clear, input, 1: synchronous, active-low reset.
- opcode, input, 5: IR[31:27], taken from sel_encode.
- mem_ready, input, 1: memory completed the current Read/Write.
- PCout, PCin, IncPC, input-side? No: all of the following are outputs, 1 bit each.
  - PC controls: PCout, PCin, IncPC.
  - MAR/MDR/IR controls: MARin, MDRin, MDRout, IRin.
  - ALU register controls: Yin, Zin, Zlowout, Cout.
  - Memory controls: Read, Write.
- Gra, Grb, Grc, Rin, Rout, BAout, output, 1 each: register-select strobes to sel_encode.
- alu_op, output, 2: 0=ADD, 1=SUB, 2=AND, 3=OR.
- run, output, 1: CPU executing.
- fault, output, 1: sticky memory timeout flag.

Behaviour:
- Output form: all outputs are a pure function of the state register (Moore); no output depends combinationally on mem_ready.
- Reset: clear is sampled low on a rising edge, so the next state is RST.
  - In RST every output is 0, including run and fault; wcnt=0.
  - RST holds while clear is low. The first edge with clear high moves to T0.
  - clear low in any state, including wait and HALT/FAULT, aborts to RST at the next edge.
- run: 1 in every state except RST, HALT and FAULT.
- Opcodes: ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, andi=01101, ori=01110, nop=11010, halt=11011.
  - All other opcodes behave as nop.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Stays in T1 until mem_ready=1 is sampled, then goes to T2.
  - T2: MDRout, IRin.
- Decode (T3 state entry): opcode is sampled at the end of T2 and is stable from T3 onward (IR loaded).
- Register ALU ops (add/sub/and/or):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op per opcode.
  - T5: Zlowout, Gra, Rin. Then T0.
- Immediate ops (addi/andi/ori):
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, alu_op=ADD/AND/OR.
  - T5: Zlowout, Gra, Rin. Then T0.
- ldi: T3 uses Grb, BAout, Yin (BAout forces R0 to read as 0). T4 uses Cout, Zin, ADD. T5 uses Zlowout, Gra, Rin.
- ld:
  - T3–T4: as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; waits on mem_ready.
  - T7: MDRout, Gra, Rin. Then T0.
- st:
  - T3–T5: as ld.
  - T6: Gra, Rout, MDRin.
  - T7: Write; waits on mem_ready. Then T0.
- nop / undefined: T3 goes to T0, with no controls asserted in T3.
- halt: T3 goes to HALT. HALT has all controls 0 and run=0, and holds until clear.
- alu_op: 0 in every state where Zin is not asserted.
- Instruction length in cycles, with zero memory wait:
  - nop: 4.
  - ALU and immediate ops: 6.
  - ld and st: 8.
- Memory wait:
  - Applies to T1, ld T6 and st T7.
  - wcnt clears on entry to the wait state and increments each cycle mem_ready=0.
  - Read/Write, and MDRin where applicable, stay asserted throughout the wait.
  - mem_ready=1 in the same cycle as entry: zero extra cycles.
  - wcnt==MEM_WAIT_MAX with mem_ready still 0: go to FAULT.
  - mem_ready=1 on the cycle wcnt==MEM_WAIT_MAX: success wins.
- FAULT: all controls 0, run=0, fault=1. Holds until clear.
- Gra/Grb/Grc: at most one of the three asserted in any state.
- Rin and Rout: never both asserted.

Test Plan:
- Reset: hold clear=0 for 3 cycles mid-T4 of an add. All outputs are 0 and run=0. After release, PCout=MARin=IncPC=Zin=1 on the first active cycle.
- add (opcode 00011), mem_ready tied 1:
  - Exact strobe sequence over 6 cycles.
  - T4 has Grc=Rout=Zin=1 and alu_op=0.
  - T5 has Gra=Rin=1.
  - Returns to T0 on cycle 7.
- ld (00000) with mem_ready delayed 3 cycles in T6: Read=MDRin=1 for 4 cycles, then T7 shows MDRout=Gra=Rin=1. Total 11 cycles.
- st (00010) with mem_ready=0 for MEM_WAIT_MAX+1 cycles in T7: fault=1 and run=0, held until clear=0.
- halt (11011) then opcode changes to add: run=0 stays low and all strobes remain 0 for 20 cycles.
- Undefined opcode 10101: 4-cycle loop, with no Rin/Write/Read asserted outside fetch.
